// File: rtl/numled_pkg.sv
// rtl/numled_pkg.sv - register layout, bus constants and seven-segment glyph ROM
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`define IO_BUS_WIDTH_ADDR 8
`define IO_BUS_WIDTH_CTRL 4
`define IO_BUS_CTRL_WE 0
`define IO_CTRL_WRITE 1'b1
`define IO_CALL_HIGHERADDR 3
`define IO_CALL_LOWERADDR 2
`define IO_CALL_CTRL 2'd0
`define IO_CALL_INOUT 2'd1
`endif

package numled_pkg;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_DEC   = 1;
  localparam int CTRL_LZS   = 2;
  localparam int DP_LSB     = 8;
  localparam int BLANK_LSB  = 16;
  localparam int ST_BUSY    = 30;
  localparam int ST_OVF     = 31;
  localparam logic [31:0] CTRL_WMASK = 32'h00FF_FF07;

  localparam int BCD_DIGITS = 10;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off here and merged later.
  function automatic logic [7:0] seg7_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    return g;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble, one input bit per clock
module bin2bcd_seq
  import numled_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DATA_W-1:0]       bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  logic [DATA_W-1:0]       sh;
  logic [CW-1:0]           cnt;
  logic [4*BCD_DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // start wins over abort so a restart with a new value never loses it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      bcd  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh   <= bin;
        bcd  <= '0;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (abort) begin
        busy <= 1'b0;
      end else if (busy) begin
        {bcd, sh} <= {adj, sh} << 1;
        cnt       <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/numled_ctrl_scan.sv
// rtl/numled_ctrl_scan.sv - bus-attached multiplexed seven-segment display controller
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`define IO_BUS_WIDTH_ADDR 8
`define IO_BUS_WIDTH_CTRL 4
`define IO_BUS_CTRL_WE 0
`define IO_CTRL_WRITE 1'b1
`define IO_CALL_HIGHERADDR 3
`define IO_CALL_LOWERADDR 2
`define IO_CALL_CTRL 2'd0
`define IO_CALL_INOUT 2'd1
`endif

module numled_ctrl_scan
  import numled_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int DATA_W   = `IO_BUS_WIDTH_DATA
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          BG,
  input  logic [`IO_BUS_WIDTH_ADDR-1:0] addr,
  input  logic [`IO_BUS_WIDTH_CTRL-1:0] ctrl,
  inout  wire  [DATA_W-1:0]             data,
  output logic [DIGITS-1:0]             led_en,
  output logic [7:0]                    led_seg
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [`IO_CALL_HIGHERADDR-`IO_CALL_LOWERADDR:0] off;
  logic we, wr_ctrl, wr_val, rd;
  logic [31:0] ctrl_q, value_q, show_q;
  logic        ovf_q, dec_q;
  logic [DATA_W-1:0] rdata;
  logic start, abort, busy, done;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic unused_bus;

  assign off     = addr[`IO_CALL_HIGHERADDR:`IO_CALL_LOWERADDR];
  assign we      = (ctrl[`IO_BUS_CTRL_WE] == `IO_CTRL_WRITE);
  assign wr_ctrl = BG && we && (off == `IO_CALL_CTRL);
  assign wr_val  = BG && we && (off == `IO_CALL_INOUT);
  assign rd      = BG && !we && ((off == `IO_CALL_CTRL) || (off == `IO_CALL_INOUT));
  assign dec_q   = ctrl_q[CTRL_DEC];
  assign unused_bus = ^{addr, ctrl};

  assign rdata = (off == `IO_CALL_CTRL) ? (ctrl_q | {ovf_q, busy, 30'd0}) : value_q;
  assign data  = rd ? rdata : 'z;

  // conversion restarts on any decimal-mode VALUE write or on DEC rising
  assign start = (wr_val && dec_q) || (wr_ctrl && data[CTRL_DEC] && !dec_q);
  assign abort = wr_ctrl && !data[CTRL_DEC];

  bin2bcd_seq #(.DATA_W(DATA_W)) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .bin   (wr_val ? data : value_q),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      value_q <= '0;
      show_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= data & CTRL_WMASK;
      if (wr_val) value_q <= data;
      if (!dec_q) begin
        show_q <= value_q;
        ovf_q  <= 1'b0;
      end else if (done) begin
        show_q <= bcd[31:0];
        ovf_q  <= |(bcd >> (4*DIGITS));
      end
    end
  end

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic          tc;
  assign tc = (presc == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tc ? '0 : presc + 1'b1;
      if (tc) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  logic [3:0]        nib;
  logic [7:0]        glyph, seg_d;
  logic [DIGITS-1:0] en_d;
  logic              upper_zero;

  assign nib        = show_q[{idx, 2'b00} +: 4];
  assign glyph      = seg7_glyph(nib);
  assign upper_zero = ((show_q >> {idx, 2'b00}) == 32'd0);

  always_comb begin
    en_d  = '1;
    seg_d = SEG_BLANK;
    if (ctrl_q[CTRL_EN] && !ctrl_q[BLANK_LSB + int'(idx)]) begin
      en_d[idx] = 1'b0;
      if (dec_q && ovf_q) begin
        seg_d = SEG_DASH;
      end else if (ctrl_q[CTRL_LZS] && dec_q && idx != '0 && upper_zero) begin
        en_d = '1;
      end else begin
        seg_d = {~ctrl_q[DP_LSB + int'(idx)], glyph[6:0]};
      end
    end
  end

  // enable and segments share one register stage so digits never ghost
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_en  <= '1;
      led_seg <= SEG_BLANK;
    end else begin
      led_en  <= en_d;
      led_seg <= seg_d;
    end
  end
endmodule
